// File: rtl/image_burst_ctrl.sv
`timescale 1ns/1ps
// image_burst_ctrl
//   Sequences the store_image_data sync FIFO between the pixel capture stream
//   and a burst-oriented sink (DDR write port). Accepted pixels are written
//   into the FIFO. Once BURST_LEN words are buffered, a burst is requested and
//   exactly that many words are drained. At end of frame the partial remainder
//   is flushed as a short burst, and then frame_done pulses.
//
// Ports
//   clk, tb_rst       clock (rising edge); asynchronous active-high reset
//   s_valid/s_data/s_eof/s_ready
//                     pixel input; s_eof marks the last pixel of a frame
//   fifo_wr_en/fifo_wr_data/fifo_full
//                     FIFO write side
//   fifo_rd_en/fifo_rd_data/fifo_empty
//                     FIFO read side; rd_data is valid 1 cycle after rd_en
//   m_req/m_len/m_ack burst request handshake; m_len is stable while m_req=1
//   m_valid/m_data/m_last
//                     burst data stream (the sink cannot stall)
//   frame_done        1-cycle pulse after the last word of a frame has left
//   err               sticky FIFO protocol error
module image_burst_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_W    = 10,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned AFULL_MARG = 4
) (
  input  logic               clk,
  input  logic               tb_rst,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_eof,
  output logic               s_ready,
  output logic               fifo_wr_en,
  output logic [DATA_W-1:0]  fifo_wr_data,
  input  logic               fifo_full,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  input  logic               fifo_empty,
  output logic               m_req,
  output logic [DEPTH_W:0]   m_len,
  input  logic               m_ack,
  output logic               m_valid,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               frame_done,
  output logic               err
);

  typedef logic [DEPTH_W:0] cnt_t;

  localparam int unsigned CAP       = 2 ** DEPTH_W;
  localparam cnt_t        AFULL_LVL = cnt_t'(CAP - AFULL_MARG);
  localparam cnt_t        BURST_W   = cnt_t'(BURST_LEN);
  localparam cnt_t        ONE       = cnt_t'(1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

  state_t state, state_nxt;
  cnt_t   occ;
  cnt_t   m_len_r, len_nxt;
  cnt_t   rd_cnt;
  logic   eof_pend;
  logic   last_rd;

  // Gating with tb_rst keeps s_ready (and hence fifo_wr_en) low while reset
  // is asserted, even though occ=0 and eof_pend=0 would otherwise enable it.
  assign s_ready      = ~tb_rst & ~eof_pend & ~fifo_full & (occ < AFULL_LVL);
  assign fifo_wr_en   = s_valid & s_ready;
  assign fifo_wr_data = s_data;
  assign m_len        = m_len_r;
  assign m_data       = m_valid ? fifo_rd_data : '0;

  always_comb begin
    state_nxt  = state;
    len_nxt    = m_len_r;
    fifo_rd_en = 1'b0;
    last_rd    = 1'b0;
    m_req      = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (occ >= BURST_W) begin
          state_nxt = REQ;
          len_nxt   = BURST_W;
        end else if (eof_pend && (occ != '0)) begin
          state_nxt = REQ;
          len_nxt   = occ;
        end else if (eof_pend) begin
          state_nxt = DONE;
        end
      end
      REQ: begin
        m_req = 1'b1;
        if (m_ack) state_nxt = BURST;
      end
      BURST: begin
        fifo_rd_en = 1'b1;
        if (rd_cnt == m_len_r - ONE) begin
          last_rd   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state    <= IDLE;
      occ      <= '0;
      m_len_r  <= '0;
      rd_cnt   <= '0;
      eof_pend <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      m_len_r <= len_nxt;
      rd_cnt  <= (state == BURST) ? rd_cnt + ONE : '0;
      unique case ({fifo_wr_en, fifo_rd_en})
        2'b10:   occ <= occ + ONE;
        2'b01:   occ <= occ - ONE;
        default: occ <= occ;
      endcase
      if (frame_done)
        eof_pend <= 1'b0;
      else if (fifo_wr_en && s_eof)
        eof_pend <= 1'b1;
      m_valid <= fifo_rd_en;
      m_last  <= last_rd;
      err     <= err | (fifo_rd_en & fifo_empty) | (fifo_wr_en & fifo_full);
    end
  end

endmodule
